// File: rtl/text_scroller_if.sv
// Host-side bundle for the text scroller: message write port, scroll control
// and the registered display outputs.
interface text_scroller_if;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [4:0]  wr_char;
  logic [3:0]  len_m1;
  logic        scroll_en;
  logic        restart;
  logic [55:0] seg_bus;
  logic [4:0]  win_start;
  logic        wrap;

  // Host drives the message and scroll controls, sees the display outputs.
  modport master (
    output wr_en, wr_addr, wr_char, len_m1, scroll_en, restart,
    input  seg_bus, win_start, wrap
  );

  // The scroller receives controls and drives the display outputs.
  modport slave (
    input  wr_en, wr_addr, wr_char, len_m1, scroll_en, restart,
    output seg_bus, win_start, wrap
  );
endinterface

// File: rtl/text_scroller.sv
// Text scroller: 16-character message RAM, an 8-character sliding window over
// "message + 8 blanks", and registered active-low 7-segment patterns for the
// downstream display multiplexer.
module text_scroller #(
  parameter int unsigned STEP_MAX = 50_000_000
) (
  input logic            CLK100MHZ,
  input logic            reset,
  text_scroller_if.slave bus
);

  localparam int unsigned PW = $clog2(STEP_MAX);
  localparam logic [PW-1:0] PresTc = PW'(STEP_MAX - 1);
  localparam logic [4:0] CodeBlank = 5'd16;

  logic [4:0]    mem_q [16];
  logic [4:0]    mem_d [16];
  logic [PW-1:0] presc_q, presc_d;
  logic [4:0]    win_q, win_d;
  logic          wrap_q, wrap_d;
  logic [3:0]    len_q, len_d;
  logic [55:0]   seg_q, seg_d;

  // Period derived from the live length input drives the window position.
  logic [4:0] per_now;
  logic       step;
  // Length registered alongside win_start keeps each displayed frame consistent.
  logic [4:0] len_seg;
  logic [4:0] per_seg;
  logic [4:0] idx;

  assign per_now = {1'b0, bus.len_m1} + 5'd9;
  assign len_seg = {1'b0, len_q} + 5'd1;
  assign per_seg = {1'b0, len_q} + 5'd9;
  assign step    = bus.scroll_en && (presc_q == PresTc);

  // Character code to active-low gfedcba pattern; unused codes are blank.
  function automatic logic [6:0] glyph(input logic [4:0] code);
    logic [6:0] g;
    case (code)
      5'd0:    g = 7'b1000000;
      5'd1:    g = 7'b1111001;
      5'd2:    g = 7'b0100100;
      5'd3:    g = 7'b0110000;
      5'd4:    g = 7'b0011001;
      5'd5:    g = 7'b0010010;
      5'd6:    g = 7'b0000010;
      5'd7:    g = 7'b1111000;
      5'd8:    g = 7'b0000000;
      5'd9:    g = 7'b0010000;
      5'd10:   g = 7'b0001000;
      5'd11:   g = 7'b0000011;
      5'd12:   g = 7'b1000110;
      5'd13:   g = 7'b0100001;
      5'd14:   g = 7'b0000110;
      5'd15:   g = 7'b0001110;
      5'd17:   g = 7'b0001001;
      5'd18:   g = 7'b1000111;
      5'd19:   g = 7'b0001100;
      5'd20:   g = 7'b1000001;
      5'd21:   g = 7'b0101111;
      5'd22:   g = 7'b0101011;
      5'd23:   g = 7'b0100011;
      5'd24:   g = 7'b0111111;
      default: g = 7'b1111111;
    endcase
    return g;
  endfunction

  // Message RAM write port.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (bus.wr_en) begin
      mem_d[bus.wr_addr] = bus.wr_char;
    end
  end

  // Prescaler and window position; restart beats a step, a shrunk period beats a step.
  always_comb begin
    presc_d = presc_q;
    win_d   = win_q;
    wrap_d  = 1'b0;
    len_d   = bus.len_m1;
    if (bus.restart) begin
      presc_d = '0;
      win_d   = '0;
    end else begin
      if (bus.scroll_en) begin
        presc_d = step ? '0 : presc_q + PW'(1);
      end
      if (win_q >= per_now) begin
        win_d = '0;
      end else if (step) begin
        if (win_q == per_now - 5'd1) begin
          win_d  = '0;
          wrap_d = 1'b1;
        end else begin
          win_d = win_q + 5'd1;
        end
      end
    end
  end

  // Window mapping: digit (7-j) shows stream index win_start + j modulo the period.
  always_comb begin
    seg_d = '1;
    idx   = '0;
    for (int j = 0; j < 8; j++) begin
      idx = win_q + 5'(j);
      if (idx >= per_seg) begin
        idx = idx - per_seg;
      end
      if (idx < len_seg) begin
        seg_d[7*(7-j) +: 7] = glyph(mem_q[idx[3:0]]);
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        mem_q[i] <= CodeBlank;
      end
      presc_q <= '0;
      win_q   <= '0;
      wrap_q  <= 1'b0;
      len_q   <= '0;
      seg_q   <= '1;
    end else begin
      for (int i = 0; i < 16; i++) begin
        mem_q[i] <= mem_d[i];
      end
      presc_q <= presc_d;
      win_q   <= win_d;
      wrap_q  <= wrap_d;
      len_q   <= len_d;
      seg_q   <= seg_d;
    end
  end

  assign bus.seg_bus   = seg_q;
  assign bus.win_start = win_q;
  assign bus.wrap      = wrap_q;

endmodule

// File: tb/tb_text_scroller.sv
// Directed bench for text_scroller with STEP_MAX = 4. Expectations are queued
// when stimulus is applied and popped when the DUT output is sampled.
module tb_text_scroller;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   m_mem [16];

  typedef struct {
    string       tag;
    logic [55:0] val;
  } exp_t;
  exp_t sb [$];

  text_scroller_if tif ();

  text_scroller #(.STEP_MAX(4)) dut (
    .CLK100MHZ (clk),
    .reset     (reset),
    .bus       (tif)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] ref_glyph(input int code);
    case (code)
      0:  return 7'b1000000;
      1:  return 7'b1111001;
      2:  return 7'b0100100;
      3:  return 7'b0110000;
      4:  return 7'b0011001;
      5:  return 7'b0010010;
      6:  return 7'b0000010;
      7:  return 7'b1111000;
      8:  return 7'b0000000;
      9:  return 7'b0010000;
      10: return 7'b0001000;
      11: return 7'b0000011;
      12: return 7'b1000110;
      13: return 7'b0100001;
      14: return 7'b0000110;
      15: return 7'b0001110;
      17: return 7'b0001001;
      18: return 7'b1000111;
      19: return 7'b0001100;
      20: return 7'b1000001;
      21: return 7'b0101111;
      22: return 7'b0101011;
      23: return 7'b0100011;
      24: return 7'b0111111;
      default: return 7'b1111111;
    endcase
  endfunction

  // Reference frame for window start w over a message of length len.
  function automatic logic [55:0] ref_frame(input int w, input int len);
    logic [55:0] f;
    int          k;
    f = '1;
    for (int j = 0; j < 8; j++) begin
      k = (w + j) % (len + 8);
      if (k < len) f[7*(7-j) +: 7] = ref_glyph(m_mem[k]);
    end
    return f;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input string tag, input logic [55:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic check_next(input logic [55:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed %h with no expectation queued", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic chk_win(input string tag, input int w, input bit wr);
    expect_val({tag, "_win"}, 56'(w));
    check_next(56'(tif.win_start));
    expect_val({tag, "_wrap"}, 56'(wr));
    check_next(56'(tif.wrap));
  endtask

  task automatic wr(input int a, input int c);
    tif.wr_en   = 1'b1;
    tif.wr_addr = 4'(a);
    tif.wr_char = 5'(c);
    m_mem[a]    = c;
    tick();
    tif.wr_en = 1'b0;
  endtask

  initial begin
    logic [55:0] hola;
    logic [55:0] ef;
    hola = {7'b0001001, 7'b1000000, 7'b1000111, 7'b0001000, {28{1'b1}}};
    ef   = {7'b0000110, 7'b0001110, {42{1'b1}}};
    for (int i = 0; i < 16; i++) m_mem[i] = 16;

    reset         = 1'b1;
    tif.wr_en     = 1'b0;
    tif.wr_addr   = '0;
    tif.wr_char   = '0;
    tif.len_m1    = '0;
    tif.scroll_en = 1'b0;
    tif.restart   = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    expect_val("reset_seg", '1);
    check_next(tif.seg_bus);
    chk_win("reset", 0, 1'b0);

    // "HOLA", frozen window; visible one edge after the last write.
    tif.len_m1 = 4'd3;
    wr(0, 17);
    wr(1, 0);
    wr(2, 18);
    wr(3, 10);
    expect_val("hola_seg", hola);
    tick();
    check_next(tif.seg_bus);
    chk_win("hola", 0, 1'b0);

    // Scroll one step every 4 cycles through P = 12.
    tif.scroll_en = 1'b1;
    for (int s = 1; s <= 11; s++) begin
      repeat (3) tick();
      chk_win("step_hold", s - 1, 1'b0);
      tick();
      chk_win("step_adv", s, 1'b0);
    end
    expect_val("win11_seg", ref_frame(11, 4));
    tick();
    check_next(tif.seg_bus);
    repeat (2) tick();
    chk_win("pre_wrap", 11, 1'b0);
    tick();
    chk_win("wrap_pulse", 0, 1'b1);
    tick();
    chk_win("wrap_end", 0, 1'b0);

    // Freeze mid-count for 10 cycles; prescaler resumes from 2.
    tick();
    tif.scroll_en = 1'b0;
    repeat (10) tick();
    chk_win("frozen", 0, 1'b0);
    tif.scroll_en = 1'b1;
    tick();
    chk_win("resume_hold", 0, 1'b0);
    tick();
    chk_win("resume_step", 1, 1'b0);

    // Restart on a terminal count, then restart mid-count.
    repeat (3) tick();
    tif.restart = 1'b1;
    tick();
    tif.restart = 1'b0;
    chk_win("restart_tc", 0, 1'b0);
    repeat (2) tick();
    tif.restart = 1'b1;
    tick();
    tif.restart = 1'b0;
    repeat (3) tick();
    chk_win("restart_presc", 0, 1'b0);
    tick();
    chk_win("restart_step", 1, 1'b0);

    // Reset wins over a simultaneous write.
    tif.scroll_en = 1'b0;
    reset         = 1'b1;
    tif.wr_en     = 1'b1;
    tif.wr_addr   = 4'd0;
    tif.wr_char   = 5'd5;
    tick();
    reset     = 1'b0;
    tif.wr_en = 1'b0;
    for (int i = 0; i < 16; i++) m_mem[i] = 16;
    expect_val("rst_wr_seg0", '1);
    check_next(tif.seg_bus);
    chk_win("rst_wr", 0, 1'b0);
    expect_val("rst_wr_seg1", '1);
    tick();
    check_next(tif.seg_bus);

    // Full 16-character message, scroll to 20, then shrink P to 12.
    tif.len_m1 = 4'd15;
    for (int i = 0; i < 16; i++) wr(i, i);
    tif.scroll_en = 1'b1;
    repeat (80) tick();
    chk_win("at20", 20, 1'b0);
    tif.len_m1 = 4'd3;
    tick();
    chk_win("shrink", 0, 1'b0);
    repeat (3) tick();
    chk_win("shrink_presc", 1, 1'b0);

    // Window at 14 over codes 0..15.
    tif.scroll_en = 1'b0;
    tif.len_m1    = 4'd15;
    tif.restart   = 1'b1;
    tick();
    tif.restart   = 1'b0;
    tif.scroll_en = 1'b1;
    repeat (56) tick();
    tif.scroll_en = 1'b0;
    chk_win("at14", 14, 1'b0);
    expect_val("ef_seg", ef);
    tick();
    check_next(tif.seg_bus);

    // Unused codes 25 and 31 render blank.
    tif.restart = 1'b1;
    tick();
    tif.restart = 1'b0;
    wr(0, 25);
    wr(1, 31);
    expect_val("unused_codes_seg", ref_frame(0, 16));
    tick();
    check_next(tif.seg_bus);
    expect_val("unused_codes_d7", 56'h7f);
    check_next(56'(tif.seg_bus[55:49]));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
